// File: rtl/ins_cache_refill_ctrl.sv
// ============================================================================
//  Module   : ins_cache_refill_ctrl
//  Purpose  : L1 I-cache refill requester. It issues one block-aligned word
//             address to L2, collects the burst into a full block and holds
//             the block until the cache acknowledges the write.
//  Option   : CRIT_WORD_FWD_EN  forwards the requested word as its beat lands
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ins_cache_refill_ctrl #(
    parameter int B      = 9,
    parameter int W      = 7,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_miss,
    input  logic [ADDR_W-1:0]     i_miss_addr,
    output logic                  o_refill_busy,
    output logic [ADDR_W-3:0]     o_addr_to_l2,
    output logic                  o_addr_to_l2_valid,
    input  logic                  i_addr_to_l2_ready,
    input  logic [(1<<W)-1:0]     i_data_from_l2,
    input  logic                  i_data_from_l2_valid,
    output logic                  o_data_from_l2_ready,
    output logic [(1<<B)-1:0]     o_block_out,
    output logic                  o_block_valid,
    input  logic                  i_block_ack,
    output logic [31:0]           o_crit_word,
    output logic                  o_crit_valid
);

    localparam int BEAT_W   = 1 << W;
    localparam int L2_BURST = 1 << (B - W);
    localparam int CNT_W    = B - W;
    localparam int WIDX_W   = W - 5;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(L2_BURST - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_BURST = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_W-3:0]     r_addr_to_l2;
    logic                  r_addr_valid;
    logic                  r_busy;
    logic                  r_block_valid;
    logic                  r_data_ready;
    logic [BEAT_W-1:0]     r_beats [L2_BURST];

    logic                  w_beat_accept;
    logic [ADDR_W-3:0]     w_block_word_addr;
    logic                  w_unused_addr_lsbs;

    // Word address of the first word in the block: drop the in-block offset.
    assign w_block_word_addr  = {i_miss_addr[ADDR_W-1:B-3], {(B-5){1'b0}}};
    assign w_beat_accept      = (r_state == S_BURST) && i_data_from_l2_valid && r_data_ready;
    assign w_unused_addr_lsbs = ^i_miss_addr[B-4:0];

`ifdef CRIT_WORD_FWD_EN
    logic [CNT_W-1:0]      r_crit_beat;
    logic [WIDX_W-1:0]     r_crit_widx;
    logic [31:0]           r_crit_word;
    logic                  r_crit_valid;
    logic                  w_crit_hit;
    logic [31:0]           w_crit_word;

    assign w_crit_hit  = w_beat_accept && (r_cnt == r_crit_beat);
    assign w_crit_word = i_data_from_l2[{r_crit_widx, 5'b0} +: 32];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_crit_beat  <= '0;
            r_crit_widx  <= '0;
            r_crit_word  <= '0;
            r_crit_valid <= 1'b0;
        end else begin
            if (r_state == S_IDLE && i_miss) begin
                r_crit_beat <= i_miss_addr[B-4:W-3];
                r_crit_widx <= i_miss_addr[W-4:2];
            end
            // Strobe lasts exactly the cycle after the matching beat lands.
            r_crit_valid <= w_crit_hit;
            if (w_crit_hit) begin
                r_crit_word <= w_crit_word;
            end
        end
    end

    assign o_crit_word  = r_crit_word;
    assign o_crit_valid = r_crit_valid;
`else
    assign o_crit_word  = 32'h0;
    assign o_crit_valid = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_addr_to_l2  <= '0;
            r_addr_valid  <= 1'b0;
            r_busy        <= 1'b0;
            r_block_valid <= 1'b0;
            r_data_ready  <= 1'b1;
            for (int k = 0; k < L2_BURST; k++) begin
                r_beats[k] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    // Beats arriving here are stale or erroneous and are dropped.
                    if (i_miss) begin
                        r_addr_to_l2 <= w_block_word_addr;
                        r_addr_valid <= 1'b1;
                        r_busy       <= 1'b1;
                        r_cnt        <= '0;
                        r_state      <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_addr_to_l2_ready) begin
                        r_addr_valid <= 1'b0;
                        r_state      <= S_BURST;
                    end
                end
                S_BURST: begin
                    if (w_beat_accept) begin
                        r_beats[r_cnt] <= i_data_from_l2;
                        r_cnt          <= r_cnt + CNT_ONE;
                        if (r_cnt == CNT_LAST) begin
                            r_state       <= S_HOLD;
                            r_block_valid <= 1'b1;
                            r_data_ready  <= 1'b0;
                        end
                    end
                end
                S_HOLD: begin
                    // A MISS coinciding with the ACK is not captured here.
                    if (i_block_ack) begin
                        r_state       <= S_IDLE;
                        r_block_valid <= 1'b0;
                        r_busy        <= 1'b0;
                        r_data_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < L2_BURST; k++) begin : g_pack
        assign o_block_out[k*BEAT_W +: BEAT_W] = r_beats[k];
    end

    assign o_refill_busy        = r_busy;
    assign o_addr_to_l2         = r_addr_to_l2;
    assign o_addr_to_l2_valid   = r_addr_valid;
    assign o_data_from_l2_ready = r_data_ready;
    assign o_block_valid        = r_block_valid;

endmodule

`default_nettype wire

// File: tb/tb_ins_cache_refill_ctrl.sv
// ============================================================================
//  Module   : tb_ins_cache_refill_ctrl
//  Purpose  : Directed bench for ins_cache_refill_ctrl with an L2 model whose
//             words equal their own byte address; blocks tracked in a queue.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ins_cache_refill_ctrl;

    localparam int L2_DELAY = 7;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_miss = 1'b0;
    logic [31:0]    i_miss_addr = '0;
    logic           o_refill_busy;
    logic [29:0]    o_addr_to_l2;
    logic           o_addr_to_l2_valid;
    logic           i_addr_to_l2_ready = 1'b0;
    logic [127:0]   i_data_from_l2 = '0;
    logic           i_data_from_l2_valid = 1'b0;
    logic           o_data_from_l2_ready;
    logic [511:0]   o_block_out;
    logic           o_block_valid;
    logic           i_block_ack = 1'b0;
    logic [31:0]    o_crit_word;
    logic           o_crit_valid;

    int checks   = 0;
    int failures = 0;
    logic [511:0] sb_q [$];

    ins_cache_refill_ctrl #(.B(9), .W(7), .ADDR_W(32)) dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .i_miss               (i_miss),
        .i_miss_addr          (i_miss_addr),
        .o_refill_busy        (o_refill_busy),
        .o_addr_to_l2         (o_addr_to_l2),
        .o_addr_to_l2_valid   (o_addr_to_l2_valid),
        .i_addr_to_l2_ready   (i_addr_to_l2_ready),
        .i_data_from_l2       (i_data_from_l2),
        .i_data_from_l2_valid (i_data_from_l2_valid),
        .o_data_from_l2_ready (o_data_from_l2_ready),
        .o_block_out          (o_block_out),
        .o_block_valid        (o_block_valid),
        .i_block_ack          (i_block_ack),
        .o_crit_word          (o_crit_word),
        .o_crit_valid         (o_crit_valid)
    );

    always #5 clk = ~clk;

    task automatic check_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_blk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole block as L2 returns it: word j holds base + 4*j.
    function automatic logic [511:0] exp_block(input logic [31:0] a);
        logic [511:0] b;
        logic [31:0]  base;
        base = {a[31:6], 6'b0};
        b    = '0;
        for (int j = 0; j < 16; j++) begin
            b[j*32 +: 32] = base + 32'(4 * j);
        end
        return b;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_b({tag, "_busy"},   o_refill_busy, 1'b0);
        check_b({tag, "_avalid"}, o_addr_to_l2_valid, 1'b0);
        check_b({tag, "_bvalid"}, o_block_valid, 1'b0);
        check_b({tag, "_dready"}, o_data_from_l2_ready, 1'b1);
        check_b({tag, "_cvalid"}, o_crit_valid, 1'b0);
    endtask

    // Called at a negedge; returns at the negedge after MISS was sampled.
    task automatic issue_miss(input logic [31:0] a, input bit accepted);
        i_miss      = 1'b1;
        i_miss_addr = a;
        @(negedge clk);
        i_miss      = 1'b0;
        if (accepted) sb_q.push_back(exp_block(a));
    endtask

    task automatic addr_phase(input logic [31:0] a, input int hold);
        logic [31:0] ea;
        int          hs;
        ea = {2'b00, a[31:6], 4'b0000};
        hs = 0;
        for (int i = 0; i < hold; i++) begin
            i_addr_to_l2_ready = 1'b0;
            check_b("req_valid_hold", o_addr_to_l2_valid, 1'b1);
            check_w("req_addr_hold", 32'(o_addr_to_l2), ea);
            @(negedge clk);
        end
        check_b("req_valid", o_addr_to_l2_valid, 1'b1);
        check_w("req_addr", 32'(o_addr_to_l2), ea);
        check_b("req_busy", o_refill_busy, 1'b1);
        i_addr_to_l2_ready = 1'b1;
        if (o_addr_to_l2_valid) hs++;
        @(negedge clk);
        if (o_addr_to_l2_valid) hs++;
        check_b("req_valid_drop", o_addr_to_l2_valid, 1'b0);
        @(negedge clk);
        i_addr_to_l2_ready = 1'b0;
        check_i("handshakes", hs, 1);
        repeat (L2_DELAY - 2) @(negedge clk);
    endtask

    // Drives beats per pat (bit i = cycle i); pattern must end with a beat.
    task automatic run_burst(input logic [31:0] a, input logic [15:0] pat, input int plen);
        logic [511:0] blk;
        logic [511:0] exp;
        logic [31:0]  crit_w;
        int           k;
        int           crit_cnt;
        int           crit_beat;
        blk       = exp_block(a);
        k         = 0;
        crit_cnt  = 0;
        crit_beat = -1;
        crit_w    = '0;
        for (int i = 0; i < plen; i++) begin
            if (pat[i]) begin
                i_data_from_l2_valid = 1'b1;
                i_data_from_l2       = blk[k*128 +: 128];
                check_b("beat_ready", o_data_from_l2_ready, 1'b1);
                k++;
            end else begin
                i_data_from_l2_valid = 1'b0;
                i_data_from_l2       = {4{32'hDEAD_BEEF}};
            end
            @(negedge clk);
            if (o_crit_valid) begin
                crit_cnt++;
                crit_beat = pat[i] ? k - 1 : -1;
                crit_w    = o_crit_word;
            end
        end
        i_data_from_l2_valid = 1'b0;
        i_data_from_l2       = '0;
        check_b("block_valid_next", o_block_valid, 1'b1);
        check_b("ready_low_hold", o_data_from_l2_ready, 1'b0);
        check_i("sb_nonempty", sb_q.size(), 1);
        if (sb_q.size() > 0) begin
            exp = sb_q.pop_front();
            check_blk("block_out", o_block_out, exp);
        end
        @(negedge clk);
        if (o_crit_valid) crit_cnt++;
`ifdef CRIT_WORD_FWD_EN
        check_i("crit_pulses", crit_cnt, 1);
        check_i("crit_beat", crit_beat, int'((a >> 4) & 32'h3));
        check_w("crit_word", crit_w, a & 32'hFFFF_FFFC);
`else
        check_i("crit_pulses", crit_cnt, 0);
        check_w("crit_word_tied", o_crit_word, 32'h0);
`endif
    endtask

    task automatic ack_block();
        i_block_ack = 1'b1;
        @(negedge clk);
        i_block_ack = 1'b0;
        check_idle_outputs("after_ack");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        check_idle_outputs("reset");
        check_blk("reset_block", o_block_out, '0);
        check_w("reset_addr", 32'(o_addr_to_l2), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // T1: basic refill
        issue_miss(32'h0000_1014, 1'b1);
        check_w("t1_addr", 32'(o_addr_to_l2), 32'h0000_0400);
        addr_phase(32'h0000_1014, 2);
        run_burst(32'h0000_1014, 16'h000F, 4);
        check_w("t1_word5", o_block_out[5*32 +: 32], 32'h0000_1014);
        check_w("t1_word15", o_block_out[15*32 +: 32], 32'h0000_103C);
        ack_block();

        // T2: READY withheld five cycles
        repeat (2) @(negedge clk);
        issue_miss(32'h0000_8A40, 1'b1);
        addr_phase(32'h0000_8A40, 5);
        run_burst(32'h0000_8A40, 16'h000F, 4);
        ack_block();

        // T3: ACK withheld, MISS during hold and MISS coinciding with ACK
        issue_miss(32'h0000_40C8, 1'b1);
        addr_phase(32'h0000_40C8, 0);
        run_burst(32'h0000_40C8, 16'h000F, 4);
        for (int i = 0; i < 10; i++) begin
            check_b("t3_bvalid", o_block_valid, 1'b1);
            check_b("t3_dready", o_data_from_l2_ready, 1'b0);
            check_b("t3_avalid", o_addr_to_l2_valid, 1'b0);
            i_miss      = (i == 4);
            i_miss_addr = 32'h0000_5000;
            @(negedge clk);
        end
        i_block_ack = 1'b1;
        i_miss      = 1'b1;
        @(negedge clk);
        i_block_ack = 1'b0;
        i_miss      = 1'b0;
        check_idle_outputs("t3_ack_miss");
        @(negedge clk);
        check_b("t3_no_req", o_addr_to_l2_valid, 1'b0);
        check_b("t3_no_busy", o_refill_busy, 1'b0);

        // T4: reset after beat 1, late beats must be dropped
        issue_miss(32'h0000_3000, 1'b1);
        addr_phase(32'h0000_3000, 0);
        begin
            logic [511:0] blk4;
            blk4 = exp_block(32'h0000_3000);
            for (int k = 0; k < 2; k++) begin
                i_data_from_l2_valid = 1'b1;
                i_data_from_l2       = blk4[k*128 +: 128];
                @(negedge clk);
            end
            i_data_from_l2 = blk4[2*128 +: 128];
            #2 rst_n = 1'b0;
            #1;
            check_idle_outputs("t4_reset");
            check_blk("t4_reset_block", o_block_out, '0);
            check_w("t4_reset_addr", 32'(o_addr_to_l2), 32'h0);
            @(negedge clk);
            rst_n          = 1'b1;
            i_data_from_l2 = blk4[3*128 +: 128];
            @(negedge clk);
            i_data_from_l2_valid = 1'b0;
            i_data_from_l2       = '0;
        end
        sb_q.delete();
        check_blk("t4_late_dropped", o_block_out, '0);
        check_idle_outputs("t4_after");
        @(negedge clk);
        issue_miss(32'h0000_2000, 1'b1);
        addr_phase(32'h0000_2000, 1);
        run_burst(32'h0000_2000, 16'h000F, 4);
        ack_block();

        // T5: gapped beats 1,0,1,0,0,1,1
        issue_miss(32'h0000_0580, 1'b1);
        addr_phase(32'h0000_0580, 1);
        run_burst(32'h0000_0580, 16'b110_0101, 7);
        ack_block();

        // T6: requested word in the last beat
        issue_miss(32'h0000_1034, 1'b1);
        addr_phase(32'h0000_1034, 0);
        run_burst(32'h0000_1034, 16'h000F, 4);
        ack_block();

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
